key_event_encoder: RTL and testbench

Producer side of the 7-bit `keyboard_input` event word consumed by the game controller. It receives the PS/2 keyboard serial stream and decodes make, break and extended scan codes. It then encodes the five game actions as a 2-bit edge code plus a 5-bit one-hot action, so the controller sees press, hold and release phases directly.

---
 rtl/game_key_pkg.sv | 77 +++++++
 rtl/key_event_encoder_if.sv | 32 +++
 rtl/ps2_rx.sv | 122 ++++++++++++
 rtl/key_event_encoder.sv | 136 +++++++++++++
 tb/tb_key_event_encoder.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_key_pkg.sv
// ---------------------------------------------------------------------------
// game_key_pkg
// Shared definitions for the keyboard event path and the game controller:
//   - edge codes carried in keyboard_input[6:5] (press/hold/release/idle)
//   - the five one-hot game actions carried in keyboard_input[4:0]
//   - PS/2 set-2 scan codes for the mapped keys and the E0/F0 prefixes
//   - mapKey(): translates a resolved scan code into a one-hot action
// Build option: KEY_ARROW_EN enables the E0-prefixed arrow keys as
// alternate keys inside mapKey().
// ---------------------------------------------------------------------------
package game_key_pkg;

    // Edge code: bit 0 set means a key is currently held (press or hold).
    typedef enum logic [1:0] {
        EDGE_IDLE    = 2'b00,
        EDGE_PRESS   = 2'b01,
        EDGE_HOLD    = 2'b11,
        EDGE_RELEASE = 2'b10
    } edge_code_e;

    typedef struct packed {
        edge_code_e  edgeCode;
        logic [4:0]  action;
    } key_event_t;

    localparam logic [4:0] ACT_NONE        = 5'b00000;
    localparam logic [4:0] ACT_FORWARD     = 5'b10000;
    localparam logic [4:0] ACT_BACKWARD    = 5'b01000;
    localparam logic [4:0] ACT_ANGLE_UP    = 5'b00100;
    localparam logic [4:0] ACT_ANGLE_DOWN  = 5'b00010;
    localparam logic [4:0] ACT_HOLD_CANNON = 5'b00001;

    localparam logic [7:0] SC_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] SC_PREFIX_BRK = 8'hF0;

    localparam logic [7:0] SC_KEY_D      = 8'h23;
    localparam logic [7:0] SC_KEY_A      = 8'h1C;
    localparam logic [7:0] SC_KEY_W      = 8'h1D;
    localparam logic [7:0] SC_KEY_S      = 8'h1B;
    localparam logic [7:0] SC_KEY_SPACE  = 8'h29;

    localparam logic [7:0] SC_EXT_RIGHT  = 8'h74;
    localparam logic [7:0] SC_EXT_LEFT   = 8'h6B;
    localparam logic [7:0] SC_EXT_UP     = 8'h75;
    localparam logic [7:0] SC_EXT_DOWN   = 8'h72;

    // Returns ACT_NONE for any code that is not a game key. Extended codes
    // only map when the arrow option is built in; otherwise they are
    // swallowed here so they never alias onto the plain letter keys.
    function automatic logic [4:0] mapKey(input logic [7:0] code, input logic ext);
        logic [4:0] act;
        act = ACT_NONE;
        if (!ext) begin
            case (code)
                SC_KEY_D:     act = ACT_FORWARD;
                SC_KEY_A:     act = ACT_BACKWARD;
                SC_KEY_W:     act = ACT_ANGLE_UP;
                SC_KEY_S:     act = ACT_ANGLE_DOWN;
                SC_KEY_SPACE: act = ACT_HOLD_CANNON;
                default:      act = ACT_NONE;
            endcase
        end
`ifdef KEY_ARROW_EN
        else begin
            case (code)
                SC_EXT_RIGHT: act = ACT_FORWARD;
                SC_EXT_LEFT:  act = ACT_BACKWARD;
                SC_EXT_UP:    act = ACT_ANGLE_UP;
                SC_EXT_DOWN:  act = ACT_ANGLE_DOWN;
                default:      act = ACT_NONE;
            endcase
        end
`endif
        return act;
    endfunction

endpackage

// File: rtl/key_event_encoder_if.sv
// ---------------------------------------------------------------------------
// key_event_encoder_if
// Bundles the keyboard-side pins and the event word towards the controller.
//   ps2_clk, ps2_data   raw PS/2 lines (asynchronous to the system clock)
//   keyboard_input[6:0] {edge code, one-hot action}, registered
//   frame_err           one-cycle pulse on a bad or timed-out PS/2 frame
// Modports:
//   master  drives the PS/2 lines and observes the event word
//   slave   the encoder: reads the PS/2 lines, drives the event word
// ---------------------------------------------------------------------------
interface key_event_encoder_if;

    logic       ps2_clk;
    logic       ps2_data;
    logic [6:0] keyboard_input;
    logic       frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  keyboard_input,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output keyboard_input,
        output frame_err
    );

endinterface

// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
// PS/2 device-to-host frame receiver.
// Ports:
//   clock, rst      system clock, asynchronous active-high reset
//   ps2_clk_i       raw PS/2 clock
//   ps2_data_i      raw PS/2 data
//   byte_valid_o    one-cycle pulse when a good frame completes
//   byte_data_o     received byte, valid while byte_valid_o is high
//   frame_err_o     one-cycle pulse on start/parity/stop error or timeout
// Frame: start(0), 8 data bits LSB first, odd parity, stop(1). Both lines go
// through 2-flop synchronizers; data is sampled on the synced clock's fall.
// ---------------------------------------------------------------------------
module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    logic [1:0]    clkSync_q;
    logic [1:0]    dataSync_q;
    logic          clkPrev_q;
    logic [3:0]    bitCount_q, bitCount_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          byteValid_q, byteValid_d;
    logic          frameErr_q, frameErr_d;

    logic          fallEdge;
    logic          dataBit;

    assign fallEdge = clkPrev_q & ~clkSync_q[1];
    assign dataBit  = dataSync_q[1];

    // Synchronizers reset to the idle-high line level so leaving reset never
    // looks like a falling edge.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            clkPrev_q  <= 1'b1;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2_clk_i};
            dataSync_q <= {dataSync_q[0], ps2_data_i};
            clkPrev_q  <= clkSync_q[1];
        end
    end

    // Bit position 0 waits for the start bit, 1..8 shift data in from the
    // top (LSB arrives first), 9 captures parity, 10 checks stop and parity.
    // The idle timer restarts on every falling edge and saturates otherwise;
    // it only matters while a frame is partially received.
    always_comb begin
        bitCount_d  = bitCount_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        byteValid_d = 1'b0;
        frameErr_d  = 1'b0;
        timer_d     = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_ONE;

        if (fallEdge) begin
            timer_d = '0;
            if (bitCount_q == 4'd0) begin
                if (!dataBit) begin
                    bitCount_d = 4'd1;
                end else begin
                    frameErr_d = 1'b1;
                end
            end else if (bitCount_q <= 4'd8) begin
                shift_d    = {dataBit, shift_q[7:1]};
                bitCount_d = bitCount_q + 4'd1;
            end else if (bitCount_q == 4'd9) begin
                parity_d   = dataBit;
                bitCount_d = 4'd10;
            end else begin
                bitCount_d = 4'd0;
                if (dataBit && (^{shift_q, parity_q})) begin
                    byteValid_d = 1'b1;
                end else begin
                    frameErr_d = 1'b1;
                end
            end
        end else if ((bitCount_q != 4'd0) && (timer_q == TIMER_MAX)) begin
            bitCount_d = 4'd0;
            frameErr_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            bitCount_q  <= 4'd0;
            shift_q     <= 8'd0;
            parity_q    <= 1'b0;
            timer_q     <= '0;
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            bitCount_q  <= bitCount_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            timer_q     <= timer_d;
            byteValid_q <= byteValid_d;
            frameErr_q  <= frameErr_d;
        end
    end

    assign byte_valid_o = byteValid_q;
    assign byte_data_o  = shift_q;
    assign frame_err_o  = frameErr_q;

endmodule

// File: rtl/key_event_encoder.sv
// ---------------------------------------------------------------------------
// key_event_encoder
// Turns the PS/2 keyboard stream into the 7-bit keyboard_input event word
// {edge code, one-hot action} for the game controller.
// Ports:
//   clock   system clock
//   rst     asynchronous active-high reset
//   bus     key_event_encoder_if.slave: ps2_clk, ps2_data in;
//           keyboard_input[6:0], frame_err out
// Parameter TIMEOUT_CYCLES: idle cycles before a partial frame is dropped.
// Build option: KEY_ARROW_EN adds E0-prefixed arrow keys as alternate keys;
// without it every extended make/break is ignored.
// ---------------------------------------------------------------------------
module key_event_encoder
    import game_key_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              clock,
    input  logic              rst,
    key_event_encoder_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    logic       byteValid;
    logic [7:0] byteData;
    logic       frameErr;

    logic [1:0] prefix_q, prefix_d;
    logic       isMake;
    logic       isBreak;
    logic       isExt;
    logic [4:0] keyAction;
    logic [4:0] activeAction;

    key_event_t kbd_q, kbd_d;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clock        (clock),
        .rst          (rst),
        .ps2_clk_i    (bus.ps2_clk),
        .ps2_data_i   (bus.ps2_data),
        .byte_valid_o (byteValid),
        .byte_data_o  (byteData),
        .frame_err_o  (frameErr)
    );

    // Prefix tracking: E0 and F0 only steer the state; any other byte
    // resolves as a make or break and returns to IDLE. A bad frame drops
    // any half-collected prefix so it cannot attach to the next key.
    always_comb begin
        prefix_d = prefix_q;
        isMake   = 1'b0;
        isBreak  = 1'b0;
        isExt    = 1'b0;
        if (frameErr) begin
            prefix_d = ST_IDLE;
        end else if (byteValid) begin
            case (prefix_q)
                ST_IDLE: begin
                    if (byteData == SC_PREFIX_EXT) begin
                        prefix_d = ST_EXT;
                    end else if (byteData == SC_PREFIX_BRK) begin
                        prefix_d = ST_BRK;
                    end else begin
                        isMake = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (byteData == SC_PREFIX_BRK) begin
                        prefix_d = ST_EXT_BRK;
                    end else begin
                        isMake   = 1'b1;
                        isExt    = 1'b1;
                        prefix_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    isBreak  = 1'b1;
                    prefix_d = ST_IDLE;
                end
                default: begin
                    isBreak  = 1'b1;
                    isExt    = 1'b1;
                    prefix_d = ST_IDLE;
                end
            endcase
        end
    end

    assign keyAction = mapKey(byteData, isExt);

    // The output register doubles as the active-key record: a key is held
    // exactly while the edge code shows press or hold.
    assign activeAction = ((kbd_q.edgeCode == EDGE_PRESS) || (kbd_q.edgeCode == EDGE_HOLD))
                          ? kbd_q.action : ACT_NONE;

    // While a key is held, only its own break ends the hold; everything else,
    // including typematic repeats, keeps it in hold. Press and release each
    // last one cycle because the next cycle re-evaluates from the held state.
    always_comb begin
        kbd_d.edgeCode = EDGE_IDLE;
        kbd_d.action   = ACT_NONE;
        if (activeAction != ACT_NONE) begin
            kbd_d.action = activeAction;
            if (isBreak && (keyAction == activeAction)) begin
                kbd_d.edgeCode = EDGE_RELEASE;
            end else begin
                kbd_d.edgeCode = EDGE_HOLD;
            end
        end else if (isMake && (keyAction != ACT_NONE)) begin
            kbd_d.edgeCode = EDGE_PRESS;
            kbd_d.action   = keyAction;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            prefix_q <= ST_IDLE;
            kbd_q    <= '0;
        end else begin
            prefix_q <= prefix_d;
            kbd_q    <= kbd_d;
        end
    end

    assign bus.keyboard_input = kbd_q;
    assign bus.frame_err      = frameErr;

endmodule

// File: tb/tb_key_event_encoder.sv
// ---------------------------------------------------------------------------
// tb_key_event_encoder
// Drives PS/2 frames into key_event_encoder and checks every change of the
// event word and every frame_err pulse against an expected-event queue that
// is filled as stimulus is issued. Press/release events and parity errors
// also have their latency from the sampling PS/2 falling edge checked.
// ---------------------------------------------------------------------------
module tb_key_event_encoder;

    localparam int TIMEOUT = 300;
    localparam int HALF    = 10;

    typedef struct {
        logic [7:0] val;
        int         lat;
        string      tag;
    } exp_t;

    logic clock = 1'b0;
    logic rst   = 1'b0;

    key_event_encoder_if kbdIf();

    key_event_encoder #(
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (kbdIf)
    );

    always #5 clock = ~clock;

    exp_t       expQ[$];
    int         checkCount    = 0;
    int         passCount     = 0;
    int         failCount     = 0;
    int         cycleCnt      = 0;
    int         lastStopCycle = 0;
    bit         monEn         = 1'b0;
    logic [6:0] prevKbd       = 7'd0;

    initial begin
        forever begin
            @(posedge clock);
            cycleCnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input string tag, input logic [7:0] val, input int lat);
        exp_t e;
        e.tag = tag;
        e.val = val;
        e.lat = lat;
        expQ.push_back(e);
    endtask

    task automatic popCompare(input logic [7:0] obs);
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput("unexpected_event", {24'd0, obs}, 32'h100);
        end else begin
            e = expQ.pop_front();
            checkOutput(e.tag, {24'd0, obs}, {24'd0, e.val});
            if (e.lat >= 0) begin
                checkOutput({e.tag, "_latency"}, cycleCnt - lastStopCycle, e.lat);
            end
        end
    endtask

    // Monitor: every change of keyboard_input and every frame_err pulse
    // consumes one expected event; press and release must last one cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (monEn) begin
                if (prevKbd[6:5] == 2'b01 || prevKbd[6:5] == 2'b10) begin
                    checkOutput("single_cycle_phase", {31'd0, kbdIf.keyboard_input !== prevKbd}, 32'd1);
                end
                if (kbdIf.frame_err !== 1'b0) begin
                    popCompare(8'h80);
                end
                if (kbdIf.keyboard_input !== prevKbd) begin
                    popCompare({1'b0, kbdIf.keyboard_input});
                end
                prevKbd = kbdIf.keyboard_input;
            end
        end
    end

    function automatic logic [10:0] makeFrame(input logic [7:0] b, input bit goodParity);
        logic par;
        par = goodParity ? ~^b : ^b;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic applyBits(input logic [10:0] bits, input int nBits);
        for (int i = 0; i < nBits; i++) begin
            @(posedge clock); #1;
            kbdIf.ps2_data = bits[i];
            repeat (HALF) @(posedge clock);
            #1;
            kbdIf.ps2_clk = 1'b0;
            lastStopCycle = cycleCnt;
            repeat (HALF) @(posedge clock);
            #1;
            kbdIf.ps2_clk = 1'b1;
        end
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        applyBits(makeFrame(b, 1'b1), 11);
    endtask

    task automatic settle(input string tag);
        repeat (30) @(posedge clock);
        #1;
        checkOutput({tag, "_drained"}, expQ.size(), 0);
    endtask

    initial begin
        kbdIf.ps2_clk  = 1'b1;
        kbdIf.ps2_data = 1'b1;

        // Reset
        #1 rst = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_kbd", {25'd0, kbdIf.keyboard_input}, 32'h00);
        checkOutput("reset_ferr", {31'd0, kbdIf.frame_err}, 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("post_reset_kbd", {25'd0, kbdIf.keyboard_input}, 32'h00);
        monEn = 1'b1;

        // Forward press / hold / release
        $display("[TB] forward press/release");
        pushExp("fwd_press", 8'h30, 4);
        pushExp("fwd_hold", 8'h70, -1);
        applyStimulus(8'h23);
        repeat (20) @(posedge clock);
        #1;
        applyStimulus(8'hF0);
        checkOutput("fwd_hold_level", {25'd0, kbdIf.keyboard_input}, 32'h70);
        pushExp("fwd_release", 8'h50, 4);
        pushExp("fwd_idle", 8'h00, -1);
        applyStimulus(8'h23);
        settle("fwd");

        // Typematic repeats of the held key
        $display("[TB] typematic");
        pushExp("rep_press", 8'h21, 4);
        pushExp("rep_hold", 8'h61, -1);
        applyStimulus(8'h29);
        applyStimulus(8'h29);
        applyStimulus(8'h29);
        checkOutput("rep_hold_level", {25'd0, kbdIf.keyboard_input}, 32'h61);
        applyStimulus(8'hF0);
        pushExp("rep_release", 8'h41, 4);
        pushExp("rep_idle", 8'h00, -1);
        applyStimulus(8'h29);
        settle("rep");

        // Overlapping keys: second key ignored while A is held
        $display("[TB] overlap");
        pushExp("ovl_press", 8'h28, 4);
        pushExp("ovl_hold", 8'h68, -1);
        applyStimulus(8'h1C);
        applyStimulus(8'h23);
        applyStimulus(8'hF0);
        applyStimulus(8'h23);
        checkOutput("ovl_hold_level", {25'd0, kbdIf.keyboard_input}, 32'h68);
        applyStimulus(8'hF0);
        pushExp("ovl_release", 8'h48, 4);
        pushExp("ovl_idle", 8'h00, -1);
        applyStimulus(8'h1C);
        settle("ovl");

        // Parity error
        $display("[TB] parity error");
        pushExp("parity_err", 8'h80, 3);
        applyBits(makeFrame(8'h1D, 1'b0), 11);
        settle("parity");
        checkOutput("parity_kbd", {25'd0, kbdIf.keyboard_input}, 32'h00);

        // Timeout on a partial frame, then recovery
        $display("[TB] timeout recovery");
        pushExp("timeout_err", 8'h80, -1);
        applyBits(makeFrame(8'h1D, 1'b1), 5);
        repeat (TIMEOUT + 60) @(posedge clock);
        #1;
        checkOutput("timeout_seen", expQ.size(), 0);
        pushExp("to_press", 8'h22, 4);
        pushExp("to_hold", 8'h62, -1);
        applyStimulus(8'h1B);
        applyStimulus(8'hF0);
        pushExp("to_release", 8'h42, 4);
        pushExp("to_idle", 8'h00, -1);
        applyStimulus(8'h1B);
        settle("timeout");

        // Reset during hold: clears without a release
        $display("[TB] reset during hold");
        pushExp("rh_press", 8'h24, 4);
        pushExp("rh_hold", 8'h64, -1);
        applyStimulus(8'h1D);
        repeat (10) @(posedge clock);
        #1;
        checkOutput("rh_hold_level", {25'd0, kbdIf.keyboard_input}, 32'h64);
        pushExp("rh_clear", 8'h00, -1);
        @(posedge clock);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rh_kbd_in_reset", {25'd0, kbdIf.keyboard_input}, 32'h00);
        checkOutput("rh_ferr_in_reset", {31'd0, kbdIf.frame_err}, 32'd0);
        repeat (3) @(posedge clock);
        #1;
        rst = 1'b0;
        settle("rh");
        checkOutput("rh_kbd_after", {25'd0, kbdIf.keyboard_input}, 32'h00);

        // Extended codes: E0 1D never aliases onto W
        $display("[TB] extended codes");
        applyStimulus(8'hE0);
        applyStimulus(8'h1D);
        settle("ext_alias");
        checkOutput("ext_alias_kbd", {25'd0, kbdIf.keyboard_input}, 32'h00);
`ifdef KEY_ARROW_EN
        pushExp("arrow_press", 8'h24, 4);
        pushExp("arrow_hold", 8'h64, -1);
`endif
        applyStimulus(8'hE0);
        applyStimulus(8'h75);
        repeat (10) @(posedge clock);
        #1;
`ifdef KEY_ARROW_EN
        checkOutput("arrow_level", {25'd0, kbdIf.keyboard_input}, 32'h64);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        pushExp("arrow_release", 8'h44, 4);
        pushExp("arrow_idle", 8'h00, -1);
        applyStimulus(8'h75);
`else
        checkOutput("arrow_ignored", {25'd0, kbdIf.keyboard_input}, 32'h00);
`endif
        settle("arrow");
        checkOutput("final_kbd", {25'd0, kbdIf.keyboard_input}, 32'h00);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
